// File: rtl/seeprom_banked.sv
// Banked secure EEPROM behind an I2C slave. Each bank can be locked until reset;
// accesses that touch a locked bank are NACKed and never reach the storage array.
module seeprom_banked #(
  parameter int unsigned MEM_BYTES     = 256,
  parameter int unsigned NUM_BANKS     = 4,
  parameter logic [3:0]  EEPROM_PREFIX = 4'b1010,
  parameter logic [3:0]  LOCK_PREFIX   = 4'b0101
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_i2c_scl,
  input  logic                 i_i2c_sda,
  output logic                 o_i2c_sda,
  output logic [NUM_BANKS-1:0] o_lock
);

  localparam int unsigned AW        = $clog2(MEM_BYTES);
  localparam int unsigned BankShift = AW - $clog2(NUM_BANKS);
  localparam logic [AW-1:0] AddrOne = 1;

  typedef enum logic [3:0] {
    StIdle, StStart, StCtrl, StAckAddr, StAddr, StAckWr, StWr,
    StAckRd, StRd, StRdMack, StLockAck, StLockMask, StAckIdle, StNack
  } state_e;

  logic scl_meta_q, scl_sync_q, scl_hist_q;
  logic sda_meta_q, sda_sync_q, sda_hist_q;

  state_e                 state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [6:0]             shift_q, shift_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic                   addr_valid_q, addr_valid_d;
  logic [NUM_BANKS-1:0]   lock_q, lock_d;
  logic                   sda_q, sda_d;

  logic [7:0]             mem_q [MEM_BYTES];
  logic                   mem_we;

  logic                   scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]             byte_in, rd_byte;
  logic [AW-1:0]          addr_inc, addr_new;

  // Bank index is the top address bits; shifting the mask by it puts that bank's bit at 0.
  function automatic logic bank_locked(input logic [AW-1:0] addr,
                                       input logic [NUM_BANKS-1:0] mask);
    logic [NUM_BANKS-1:0] shifted;
    shifted = mask >> (addr >> BankShift);
    return shifted[0];
  endfunction

  assign scl_rise  = scl_sync_q & ~scl_hist_q;
  assign scl_fall  = ~scl_sync_q & scl_hist_q;
  assign start_det = scl_sync_q & scl_hist_q & sda_hist_q & ~sda_sync_q;
  assign stop_det  = scl_sync_q & scl_hist_q & ~sda_hist_q & sda_sync_q;

  assign byte_in  = {shift_q, sda_sync_q};
  assign rd_byte  = mem_q[addr_q];
  assign addr_inc = addr_q + AddrOne;
  assign addr_new = byte_in[AW-1:0];

  assign o_i2c_sda = sda_q;
  assign o_lock    = lock_q;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    addr_d       = addr_q;
    addr_valid_d = addr_valid_q;
    lock_d       = lock_q;
    sda_d        = sda_q;
    mem_we       = 1'b0;

    if (scl_fall) begin
      unique case (state_q)
        StAckAddr, StAckWr, StAckRd, StLockAck, StAckIdle: sda_d = 1'b0;
        StRd: begin
          if (bit_cnt_q < 4'd8) begin
            sda_d     = rd_byte[3'd7 - bit_cnt_q[2:0]];
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
            sda_d = 1'b1;
          end
        end
        StStart: begin
          sda_d     = 1'b1;
          state_d   = StCtrl;
          bit_cnt_d = '0;
        end
        default: sda_d = 1'b1;
      endcase
    end

    if (scl_rise) begin
      unique case (state_q)
        StCtrl, StAddr, StWr, StLockMask: begin
          shift_d   = byte_in[6:0];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            unique case (state_q)
              StCtrl: begin
                if (byte_in[7:4] == EEPROM_PREFIX) begin
                  if (!byte_in[0]) begin
                    state_d = StAckAddr;
                  end else if (addr_valid_q && !bank_locked(addr_q, lock_q)) begin
                    state_d = StAckRd;
                  end else begin
                    state_d = StNack;
                  end
                end else if (byte_in[7:4] == LOCK_PREFIX) begin
                  state_d = StLockAck;
                end else begin
                  state_d = StNack;
                end
              end
              StAddr: begin
                addr_d = addr_new;
                if (bank_locked(addr_new, lock_q)) begin
                  state_d      = StNack;
                  addr_valid_d = 1'b0;
                end else begin
                  state_d      = StAckWr;
                  addr_valid_d = 1'b1;
                end
              end
              StWr: begin
                if (!bank_locked(addr_q, lock_q)) begin
                  mem_we  = 1'b1;
                  addr_d  = addr_inc;
                  state_d = StAckWr;
                end else begin
                  state_d = StNack;
                end
              end
              default: begin
                lock_d  = lock_q | byte_in[NUM_BANKS-1:0];
                state_d = StAckIdle;
              end
            endcase
          end
        end
        StAckAddr: begin state_d = StAddr;     bit_cnt_d = '0; end
        StAckWr:   begin state_d = StWr;       bit_cnt_d = '0; end
        StAckRd:   begin state_d = StRd;       bit_cnt_d = '0; end
        StLockAck: begin state_d = StLockMask; bit_cnt_d = '0; end
        StAckIdle, StNack: state_d = StIdle;
        StRd: begin
          if (bit_cnt_q == 4'd8) begin
            state_d   = StRdMack;
            bit_cnt_d = '0;
          end
        end
        StRdMack: begin
          // Master ACK continues the burst without a slave ACK phase.
          if (!sda_sync_q) begin
            addr_d  = addr_inc;
            state_d = bank_locked(addr_inc, lock_q) ? StNack : StRd;
          end else begin
            state_d = StIdle;
          end
        end
        default: ;
      endcase
    end

    if (stop_det) begin
      state_d      = StIdle;
      addr_valid_d = 1'b0;
      sda_d        = 1'b1;
      bit_cnt_d    = '0;
    end else if (start_det) begin
      state_d   = StStart;
      bit_cnt_d = '0;
    end
  end

  // Synchronizers reset to the idle-bus level so reset release creates no false edges.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_meta_q   <= 1'b1;
      scl_sync_q   <= 1'b1;
      scl_hist_q   <= 1'b1;
      sda_meta_q   <= 1'b1;
      sda_sync_q   <= 1'b1;
      sda_hist_q   <= 1'b1;
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      lock_q       <= '0;
      sda_q        <= 1'b1;
    end else begin
      scl_meta_q   <= i_i2c_scl;
      scl_sync_q   <= scl_meta_q;
      scl_hist_q   <= scl_sync_q;
      sda_meta_q   <= i_i2c_sda;
      sda_sync_q   <= sda_meta_q;
      sda_hist_q   <= sda_sync_q;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      lock_q       <= lock_d;
      sda_q        <= sda_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem_q[addr_q] <= byte_in;
    end
  end

endmodule

// File: tb/tb_seeprom_banked.sv
// Directed bench: an I2C master model drives a default DUT and a 64-byte/8-bank DUT.
module tb_seeprom_banked;

  localparam int Q = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sel   = 1'b0;
  logic       sda_a, sda_b, bus_a, bus_b;
  logic [3:0] lock_a;
  logic [7:0] lock_b;
  int         errors = 0;
  int         checks = 0;

  assign bus_a = m_sda & sda_a;
  assign bus_b = m_sda & sda_b;

  always #5 clk = ~clk;

  seeprom_banked #(.MEM_BYTES(256), .NUM_BANKS(4)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_i2c_scl(m_scl), .i_i2c_sda(bus_a),
    .o_i2c_sda(sda_a), .o_lock(lock_a)
  );

  seeprom_banked #(.MEM_BYTES(64), .NUM_BANKS(8)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_i2c_scl(m_scl), .i_i2c_sda(bus_b),
    .o_i2c_sda(sda_b), .o_lock(lock_b)
  );

  function automatic logic bus_val();
    return sel ? bus_b : bus_a;
  endfunction

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; hold(Q);
    m_scl = 1'b1; hold(Q);
    m_sda = 1'b0; hold(Q);
    m_scl = 1'b0; hold(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; hold(Q);
    m_scl = 1'b1; hold(Q);
    m_sda = 1'b1; hold(2 * Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; hold(Q);
      m_scl = 1'b1; hold(2 * Q);
      m_scl = 1'b0; hold(Q);
    end
    m_sda = 1'b1; hold(Q);
    m_scl = 1'b1; hold(Q);
    ack = bus_val(); hold(Q);
    m_scl = 1'b0; hold(Q);
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      hold(Q);
      m_scl = 1'b1; hold(Q);
      d[i] = bus_val(); hold(Q);
      m_scl = 1'b0;
    end
    hold(Q);
    m_sda = mack; hold(Q);
    m_scl = 1'b1; hold(2 * Q);
    m_scl = 1'b0; hold(Q);
  endtask

  task automatic pulse_reset();
    m_scl = 1'b1; m_sda = 1'b1;
    rst_n = 1'b0; hold(2);
    rst_n = 1'b1; hold(4);
  endtask

  task automatic test_reset();
    hold(2);
    rst_n = 1'b0; hold(3);
    checks++; if (sda_a !== 1'b1) begin errors++; $display("FAIL reset_sda_a: got %b want 1", sda_a); end
    checks++; if (lock_a !== 4'h0) begin errors++; $display("FAIL reset_lock_a: got %h want 0", lock_a); end
    checks++; if (sda_b !== 1'b1) begin errors++; $display("FAIL reset_sda_b: got %b want 1", sda_b); end
    checks++; if (lock_b !== 8'h0) begin errors++; $display("FAIL reset_lock_b: got %h want 0", lock_b); end
    rst_n = 1'b1; hold(4);
  endtask

  task automatic test_write_read();
    logic a0, a1, a2, a3;
    logic [7:0] d0, d1;
    i2c_start(); wr_byte(8'hA0, a0); wr_byte(8'h10, a1); wr_byte(8'h5A, a2); wr_byte(8'hC3, a3);
    i2c_stop();
    checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin errors++; $display("FAIL wr_acks: got %b want 0000", {a0, a1, a2, a3}); end
    checks++; if (sda_a !== 1'b1) begin errors++; $display("FAIL wr_release: got %b want 1", sda_a); end
    i2c_start(); wr_byte(8'hA0, a0); wr_byte(8'h10, a1);
    i2c_start(); wr_byte(8'hA1, a2); rd_byte(1'b0, d0); rd_byte(1'b1, d1);
    i2c_stop();
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL rd_acks: got %b want 000", {a0, a1, a2}); end
    checks++; if (d0 !== 8'h5A) begin errors++; $display("FAIL rd_byte0: got %h want 5a", d0); end
    checks++; if (d1 !== 8'hC3) begin errors++; $display("FAIL rd_byte1: got %h want c3", d1); end
    checks++; if (sda_a !== 1'b1) begin errors++; $display("FAIL rd_release: got %b want 1", sda_a); end
    // Seed 0x40 before bank 1 is locked; it is read back after the next reset.
    i2c_start(); wr_byte(8'hA0, a0); wr_byte(8'h40, a1); wr_byte(8'h77, a2); i2c_stop();
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL seed_acks: got %b want 000", {a0, a1, a2}); end
  endtask

  task automatic test_lock();
    logic a0, a1;
    i2c_start(); wr_byte(8'h50, a0); wr_byte(8'h02, a1); i2c_stop();
    checks++; if ({a0, a1} !== 2'b00) begin errors++; $display("FAIL lock_acks: got %b want 00", {a0, a1}); end
    checks++; if (lock_a !== 4'b0010) begin errors++; $display("FAIL lock_mask: got %b want 0010", lock_a); end
    i2c_start(); wr_byte(8'hA0, a0); wr_byte(8'h40, a1); i2c_stop();
    checks++; if ({a0, a1} !== 2'b01) begin errors++; $display("FAIL lock_addr_nack: got %b want 01", {a0, a1}); end
    i2c_start(); wr_byte(8'hA1, a0); i2c_stop();
    checks++; if (a0 !== 1'b1) begin errors++; $display("FAIL lock_rd_nack: got %b want 1", a0); end
  endtask

  task automatic test_boundary();
    logic a0, a1, a2, a3, a4;
    logic [7:0] d0, d1, d2;
    i2c_start(); wr_byte(8'hA0, a0); wr_byte(8'h3E, a1);
    wr_byte(8'h11, a2); wr_byte(8'h22, a3); wr_byte(8'h33, a4); i2c_stop();
    checks++; if ({a0, a1, a2, a3, a4} !== 5'b00001) begin
      errors++; $display("FAIL bnd_wr_acks: got %b want 00001", {a0, a1, a2, a3, a4});
    end
    i2c_start(); wr_byte(8'hA0, a0); wr_byte(8'h3E, a1);
    i2c_start(); wr_byte(8'hA1, a2);
    rd_byte(1'b0, d0); rd_byte(1'b0, d1); rd_byte(1'b1, d2); i2c_stop();
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL bnd_rd_acks: got %b want 000", {a0, a1, a2}); end
    checks++; if (d0 !== 8'h11) begin errors++; $display("FAIL bnd_rd_3e: got %h want 11", d0); end
    checks++; if (d1 !== 8'h22) begin errors++; $display("FAIL bnd_rd_3f: got %h want 22", d1); end
    checks++; if (d2 !== 8'hFF) begin errors++; $display("FAIL bnd_rd_locked_release: got %h want ff", d2); end
  endtask

  task automatic test_async_reset();
    logic a0, a1, a2;
    logic [7:0] d0;
    logic [7:0] partial;
    partial = 8'hE7;
    i2c_start(); wr_byte(8'hA0, a0); wr_byte(8'h20, a1); wr_byte(8'h5C, a2); i2c_stop();
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL ar_seed_acks: got %b want 000", {a0, a1, a2}); end
    checks++; if (lock_a !== 4'b0010) begin errors++; $display("FAIL ar_pre_lock: got %b want 0010", lock_a); end
    i2c_start(); wr_byte(8'hA0, a0); wr_byte(8'h20, a1);
    for (int i = 7; i >= 4; i--) begin
      m_sda = partial[i]; hold(Q);
      m_scl = 1'b1; hold(2 * Q);
      m_scl = 1'b0; hold(Q);
    end
    rst_n = 1'b0; #1;
    checks++; if (sda_a !== 1'b1) begin errors++; $display("FAIL ar_sda: got %b want 1", sda_a); end
    checks++; if (lock_a !== 4'b0000) begin errors++; $display("FAIL ar_lock: got %b want 0000", lock_a); end
    m_scl = 1'b1; m_sda = 1'b1; hold(3);
    rst_n = 1'b1; hold(4);
    i2c_start(); wr_byte(8'hA0, a0); wr_byte(8'h20, a1);
    i2c_start(); wr_byte(8'hA1, a2); rd_byte(1'b1, d0); i2c_stop();
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL ar_rd_acks: got %b want 000", {a0, a1, a2}); end
    checks++; if (d0 !== 8'h5C) begin errors++; $display("FAIL ar_not_committed: got %h want 5c", d0); end
    i2c_start(); wr_byte(8'hA0, a0); wr_byte(8'h40, a1);
    i2c_start(); wr_byte(8'hA1, a2); rd_byte(1'b1, d0); i2c_stop();
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL ar_unlock_acks: got %b want 000", {a0, a1, a2}); end
    checks++; if (d0 !== 8'h77) begin errors++; $display("FAIL ar_0x40_kept: got %h want 77", d0); end
  endtask

  task automatic test_wrap();
    logic a0, a1, a2, a3;
    logic [7:0] d0, d1;
    i2c_start(); wr_byte(8'hA0, a0); wr_byte(8'hFF, a1); wr_byte(8'hAA, a2); wr_byte(8'hBB, a3);
    i2c_stop();
    checks++; if ({a0, a1, a2, a3} !== 4'b0000) begin errors++; $display("FAIL wrap_wr_acks: got %b want 0000", {a0, a1, a2, a3}); end
    i2c_start(); wr_byte(8'hA0, a0); wr_byte(8'hFF, a1);
    i2c_start(); wr_byte(8'hA1, a2); rd_byte(1'b0, d0); rd_byte(1'b1, d1); i2c_stop();
    checks++; if (d0 !== 8'hAA) begin errors++; $display("FAIL wrap_ff: got %h want aa", d0); end
    checks++; if (d1 !== 8'hBB) begin errors++; $display("FAIL wrap_00: got %h want bb", d1); end
  endtask

  task automatic test_small_params();
    logic a0, a1;
    sel = 1'b1;
    pulse_reset();
    i2c_start(); wr_byte(8'h50, a0); wr_byte(8'h81, a1); i2c_stop();
    checks++; if ({a0, a1} !== 2'b00) begin errors++; $display("FAIL sp_lock_acks: got %b want 00", {a0, a1}); end
    checks++; if (lock_b !== 8'h81) begin errors++; $display("FAIL sp_lock_mask: got %h want 81", lock_b); end
    i2c_start(); wr_byte(8'hA0, a0); wr_byte(8'h07, a1); i2c_stop();
    checks++; if ({a0, a1} !== 2'b01) begin errors++; $display("FAIL sp_addr_07: got %b want 01", {a0, a1}); end
    i2c_start(); wr_byte(8'hA0, a0); wr_byte(8'h08, a1); i2c_stop();
    checks++; if ({a0, a1} !== 2'b00) begin errors++; $display("FAIL sp_addr_08: got %b want 00", {a0, a1}); end
    i2c_start(); wr_byte(8'hA0, a0); wr_byte(8'h3A, a1); i2c_stop();
    checks++; if ({a0, a1} !== 2'b01) begin errors++; $display("FAIL sp_addr_3a: got %b want 01", {a0, a1}); end
    sel = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_lock();
    test_boundary();
    test_async_reset();
    test_wrap();
    test_small_params();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seeprom_banked.md
Name: seeprom_banked

Overview:
- Parametrised next-generation secure EEPROM behind an I2C slave interface.
- Byte-addressed storage is split into NUM_BANKS equal banks, each of which can be permanently locked until reset.
- Every byte access is checked against the lock state. Locked-bank accesses and bank-boundary crossings into a locked bank are NACKed without touching memory.
- Adds master ACK/NACK handling on reads, a dedicated lock-mask command and a lock-state output for the SoC.

Parameters:
MEM_BYTES, 256, storage depth in bytes; power of 2, 16..256 (one address byte).
NUM_BANKS, 4, number of lockable banks; power of 2, 1..8; bank size = MEM_BYTES/NUM_BANKS.
EEPROM_PREFIX, 4'b1010, control-byte high nibble selecting memory access.
LOCK_PREFIX, 4'b0101, control-byte high nibble selecting the lock command.

Ports:
i_clk  input  1  system clock; SCL/SDA are oversampled on this clock.
i_rst_n  input  1  reset, asynchronous, active-low.
i_i2c_scl  input  1  I2C clock from master (asynchronous).
i_i2c_sda  input  1  I2C data from bus (asynchronous).
o_i2c_sda  output  1  open-drain data drive; 1 = release, 0 = pull low.
o_lock  output  NUM_BANKS  current bank lock mask; bit b set = bank b locked.

Behaviour:
- Reset values: o_i2c_sda=1, o_lock=0, state IDLE, address_valid=0, bit counters=0. Memory contents are not reset.
- Input conditioning: SCL and SDA each pass through a 2-FF synchronizer, then a 1-cycle history register for edge detection. Response lags the bus by 3 clocks.
- Bus conditions:
  - START = SDA falling while SCL stable high. Valid from any state → START; address and address_valid are retained (repeated start).
  - STOP = SDA rising while SCL stable high. Valid from any state → IDLE, address_valid=0, o_i2c_sda=1.
  - STOP has priority over START in the same cycle.
- Timing: data bits are sampled on SCL rising. o_i2c_sda changes only in the cycle after a detected SCL falling edge.
- States: IDLE, START, CTRL, ACK_ADDR, ADDR, ACK_WR, WR, ACK_RD, RD, RD_MACK, LOCK_ACK, LOCK_MASK, ACK_IDLE, NACK.
- Control byte (CTRL) is shifted in MSB-first, 8 bits.
  - EEPROM_PREFIX, rw=0 → ACK_ADDR.
  - EEPROM_PREFIX, rw=1 → ACK_RD if address_valid and the byte at address is in an unlocked bank; else NACK.
  - LOCK_PREFIX → LOCK_ACK.
  - Any other prefix → NACK.
- ADDR: 8 bits loaded; upper bits beyond log2(MEM_BYTES) are ignored (address taken mod MEM_BYTES).
  - Target bank locked → NACK, address_valid=0.
  - Otherwise → ACK_WR, address_valid=1.
- WR: after 8 data bits, commit the write and increment the address only if the current byte's bank is unlocked. Then ACK_WR; else NACK with no write.
- RD: drive bits MSB-first on 8 SCL falling edges, then release SDA and enter RD_MACK. Sample the master's 9th bit on SCL rising:
  - 0 (ACK): increment the address; next byte's bank unlocked → RD (no slave ACK phase); locked → NACK (release bus).
  - 1 (NACK): → IDLE.
- Address wraps from MEM_BYTES-1 to 0. The wrap target is lock-checked like any other byte.
- Lock command: ACK the control byte, then load an 8-bit mask (LOCK_MASK). Lower NUM_BANKS bits are ORed into the lock register; upper bits are ignored. ACK, then IDLE. Locks are sticky until reset; a mask of 0 has no effect.
- ACK/NACK states: drive 0 (ACK) or 1 (NACK) on SCL falling; transition on the following SCL rising. NACK → IDLE.
- Asynchronous reset mid-transfer: immediate return to reset values; an in-flight write byte is not committed.

Test Plan:
- Write 0xA0, 0x10, 0x5A, 0xC3, STOP; then write 0xA0, 0x10, repeated start, 0xA1, read 2 bytes (ACK, NACK) → data 0x5A, 0xC3; all slave ACKs 0; bus released after STOP.
- Lock: 0x50, mask 0x02 → ACK, o_lock=4'b0010. Then 0xA0, 0x40 → NACK at address byte; a following 0xA1 → NACK (address_valid=0).
- Boundary crossing: bank1 locked. Write at 0x3E with bytes 0x11, 0x22, 0x33 → 0x3E and 0x3F written and ACKed; third byte NACKed; read shows 0x40 unchanged.
- Wrap: MEM_BYTES=256, nothing locked. Write at 0xFF with bytes 0xAA, 0xBB → mem[0xFF]=0xAA, mem[0x00]=0xBB.
- Asynchronous reset: assert i_rst_n=0 mid data byte → o_i2c_sda=1 within the same cycle, o_lock=0; the interrupted byte is not written.
- Non-default parameters MEM_BYTES=64, NUM_BANKS=8: lock mask 0x81 → address 0x07 NACKed, address 0x08 ACKed, address 0x3A NACKed.
